// File: rtl/accum_compute_unit.sv
// rtl/accum_compute_unit.sv - compute sequencer, skewed write controller and banked psum accumulator
// Optional feature macro: ACCUM_SATURATE_EN (signed saturating accumulate instead of wrap-around).
module accum_compute_unit #(
    parameter  int SYS_COL    = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int ACCUM_SIZE = 1024,
    localparam int PW         = 2 * DATA_WIDTH,
    localparam int ACCUM_ROW  = ACCUM_SIZE / SYS_COL,
    localparam int AW         = $clog2(ACCUM_ROW)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [DATA_WIDTH-1:0]         num_row_in,
    input  logic                          weight_fill,
    input  logic                          weight_change,
    input  logic                          fill_done,
    input  logic                          sys_valid,
    input  logic [SYS_COL-1:0][PW-1:0]    psum_in,
    input  logic                          accum_clr,
    input  logic                          rd_en,
    input  logic [AW-1:0]                 rd_addr,
    output logic                          fifo_out_ctrl_en,
    output logic                          mem_rd_ctrl_en,
    output logic [DATA_WIDTH-1:0]         num_row_out,
    output logic [AW-1:0]                 accum_wr_addr,
    output logic                          busy,
    output logic                          done,
    output logic [SYS_COL-1:0][PW-1:0]    rd_data
);

    localparam int CW = $clog2(SYS_COL) + 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_RUN, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   num_row_q, num_row_d;
    logic                    wchg_q, wchg_d;
    logic [AW-1:0]           base_q, base_d;
    logic                    seen_q, seen_d;
    logic [CW-1:0]           drain_cnt_q, drain_cnt_d;
    logic                    fifo_q, fifo_d;
    logic                    memrd_q, memrd_d;
    logic                    done_q, done_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            num_row_q   <= '0;
            wchg_q      <= 1'b0;
            base_q      <= '0;
            seen_q      <= 1'b0;
            drain_cnt_q <= '0;
            fifo_q      <= 1'b0;
            memrd_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_row_q   <= num_row_d;
            wchg_q      <= wchg_d;
            base_q      <= base_d;
            seen_q      <= seen_d;
            drain_cnt_q <= drain_cnt_d;
            fifo_q      <= fifo_d;
            memrd_q     <= memrd_d;
            done_q      <= done_d;
        end
    end

    // Pulses are registered on the transition, so they are high during the first cycle of the new state.
    always_comb begin
        state_d     = state_q;
        num_row_d   = num_row_q;
        wchg_d      = wchg_q;
        base_d      = base_q;
        seen_d      = seen_q;
        drain_cnt_d = drain_cnt_q;
        fifo_d      = 1'b0;
        memrd_d     = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    num_row_d = num_row_in;
                    wchg_d    = weight_change;
                    if (num_row_in == '0) begin
                        done_d = 1'b1;
                    end else if (weight_fill) begin
                        state_d = S_FILL;
                        fifo_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        memrd_d = 1'b1;
                        fifo_d  = weight_change;
                    end
                end
            end
            S_FILL: begin
                if (fill_done) begin
                    state_d = S_START;
                    memrd_d = 1'b1;
                    fifo_d  = wchg_q;
                end
            end
            S_START: begin
                state_d = S_RUN;
                seen_d  = 1'b0;
            end
            S_RUN: begin
                if (sys_valid) begin
                    seen_d = 1'b1;
                end else if (seen_q) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == CW'(SYS_COL - 2)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    base_d  = base_q + num_row_q[AW-1:0];
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_out_ctrl_en = fifo_q;
    assign mem_rd_ctrl_en   = memrd_q;
    assign num_row_out      = num_row_q;
    assign accum_wr_addr    = base_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

    logic [AW-1:0] k_q;
    logic          col_we   [SYS_COL];
    logic [AW-1:0] col_addr [SYS_COL];
    logic          pipe_we_q   [SYS_COL-1];
    logic [AW-1:0] pipe_addr_q [SYS_COL-1];

    // Column c sees column 0's write strobe and address c cycles later, matching the array skew.
    always_comb begin
        col_we[0]   = sys_valid;
        col_addr[0] = base_q + k_q;
        for (int c = 1; c < SYS_COL; c++) begin
            col_we[c]   = pipe_we_q[c-1];
            col_addr[c] = pipe_addr_q[c-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_q <= '0;
            for (int c = 0; c < SYS_COL - 1; c++) begin
                pipe_we_q[c]   <= 1'b0;
                pipe_addr_q[c] <= '0;
            end
        end else begin
            k_q <= sys_valid ? k_q + 1'b1 : '0;
            for (int c = 0; c < SYS_COL - 1; c++) begin
                pipe_we_q[c]   <= col_we[c];
                pipe_addr_q[c] <= col_addr[c];
            end
        end
    end

    function automatic logic [PW-1:0] acc_f(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] sum;
        sum = a + b;
`ifdef ACCUM_SATURATE_EN
        if ((a[PW-1] == b[PW-1]) && (sum[PW-1] != a[PW-1]))
            sum = a[PW-1] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
`endif
        return sum;
    endfunction

    logic [PW-1:0]        mem_q   [SYS_COL][ACCUM_ROW];
    logic [ACCUM_ROW-1:0] valid_q [SYS_COL];

    // A clear in the same cycle as a write makes the write a fresh store.
    always_ff @(posedge clk) begin
        for (int c = 0; c < SYS_COL; c++) begin
            if (col_we[c]) begin
                if (valid_q[c][col_addr[c]] && !accum_clr)
                    mem_q[c][col_addr[c]] <= acc_f(mem_q[c][col_addr[c]], psum_in[c]);
                else
                    mem_q[c][col_addr[c]] <= psum_in[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < SYS_COL; c++) valid_q[c] <= '0;
        end else begin
            if (accum_clr) begin
                for (int c = 0; c < SYS_COL; c++) valid_q[c] <= '0;
            end
            for (int c = 0; c < SYS_COL; c++) begin
                if (col_we[c]) valid_q[c][col_addr[c]] <= 1'b1;
            end
        end
    end

    logic [SYS_COL-1:0][PW-1:0] rd_data_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            for (int c = 0; c < SYS_COL; c++)
                rd_data_q[c] <= valid_q[c][rd_addr] ? mem_q[c][rd_addr] : '0;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_accum_compute_unit.sv
// tb/tb_accum_compute_unit.sv - randomized self-checking bench for accum_compute_unit
module tb_accum_compute_unit;
    localparam int SC = 4, DW = 16, PW = 32, ROW = 256, AW = 8;

    logic                   clk = 1'b0;
    logic                   rstn, en, weight_fill, weight_change, fill_done, sys_valid, accum_clr, rd_en;
    logic [DW-1:0]          num_row_in;
    logic [SC-1:0][PW-1:0]  psum_in;
    logic [AW-1:0]          rd_addr;
    logic                   fifo_out_ctrl_en, mem_rd_ctrl_en, busy, done;
    logic [DW-1:0]          num_row_out;
    logic [AW-1:0]          accum_wr_addr;
    logic [SC-1:0][PW-1:0]  rd_data;

    accum_compute_unit #(.SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(1024)) dut (
        .clk(clk), .rstn(rstn), .en(en), .num_row_in(num_row_in), .weight_fill(weight_fill),
        .weight_change(weight_change), .fill_done(fill_done), .sys_valid(sys_valid),
        .psum_in(psum_in), .accum_clr(accum_clr), .rd_en(rd_en), .rd_addr(rd_addr),
        .fifo_out_ctrl_en(fifo_out_ctrl_en), .mem_rd_ctrl_en(mem_rd_ctrl_en),
        .num_row_out(num_row_out), .accum_wr_addr(accum_wr_addr), .busy(busy), .done(done),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    logic [PW-1:0] m_mem [SC][ROW];
    bit            m_val [SC][ROW];
    int            m_base;
    logic [PW-1:0] pat   [SC][16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] acc_f(input logic [PW-1:0] a, input logic [PW-1:0] b);
`ifdef ACCUM_SATURATE_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7fffffff;
        if (s < -64'sd2147483648) return 32'h80000000;
        return s[31:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [PW-1:0] m_read(input int c, input int row);
        return m_val[c][row] ? m_mem[c][row] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < SC; c++)
            for (int r = 0; r < ROW; r++) m_val[c][r] = 1'b0;
    endtask

    task automatic rand_pat();
        for (int c = 0; c < SC; c++)
            for (int k = 0; k < 16; k++) pat[c][k] = $urandom;
    endtask

    task automatic run_pass(input int n_row, input int nval, input bit wf, input bit wc, input bit same_rd);
        int cnt;
        logic [PW-1:0] pre;
        en = 1'b1; num_row_in = n_row[DW-1:0]; weight_fill = wf; weight_change = wc;
        tick();
        en = 1'b0;
        chk("busy_start", busy, 1);
        if (wf) begin
            chk("fill_pulse", fifo_out_ctrl_en, 1);
            chk("no_early_rd", mem_rd_ctrl_en, 0);
            tick();
            chk("fill_pulse_1cyc", fifo_out_ctrl_en, 0);
            fill_done = 1'b1;
            tick();
            fill_done = 1'b0;
        end
        chk("mem_rd_pulse", mem_rd_ctrl_en, 1);
        chk("wchg_pulse", fifo_out_ctrl_en, wc);
        chk("num_row_out", num_row_out, n_row[DW-1:0]);
        tick();
        chk("mem_rd_1cyc", mem_rd_ctrl_en, 0);
        pre = m_read(0, m_base);
        for (int t = 0; t < nval + SC - 1; t++) begin
            sys_valid = (t < nval);
            for (int c = 0; c < SC; c++)
                psum_in[c] = (t >= c && t - c < nval) ? pat[c][t-c] : $urandom;
            rd_en   = same_rd && (t == 0);
            rd_addr = m_base[AW-1:0];
            tick();
            if (same_rd && t == 0) chk("rd_pre_write", rd_data[0], pre);
        end
        rd_en = 1'b0; sys_valid = 1'b0;
        chk("done_early", done, 0);
        cnt = 0;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("done_latency", cnt, 1);
        for (int k = 0; k < nval; k++)
            for (int c = 0; c < SC; c++) begin
                int idx;
                idx = (m_base + k) % ROW;
                m_mem[c][idx] = m_val[c][idx] ? acc_f(m_mem[c][idx], pat[c][k]) : pat[c][k];
                m_val[c][idx] = 1'b1;
            end
        m_base = (m_base + n_row) % ROW;
        chk("base", accum_wr_addr, m_base);
        chk("busy_end", busy, 0);
        tick();
        chk("done_1cyc", done, 0);
    endtask

    task automatic chk_rows(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            int row;
            row = (base + k) % ROW;
            rd_en = 1'b1; rd_addr = row[AW-1:0];
            tick();
            rd_en = 1'b0;
            for (int c = 0; c < SC; c++)
                chk($sformatf("rd b%0d r%0d", c, row), rd_data[c], m_read(c, row));
        end
        tick();
        chk("rd_hold", rd_data[0], m_read(0, (base + n - 1) % ROW));
    endtask

    task automatic clear_pulse();
        accum_clr = 1'b1;
        tick();
        accum_clr = 1'b0;
        model_clear();
    endtask

    initial begin
        int b;
        rstn = 1'b0; en = 0; num_row_in = '0; weight_fill = 0; weight_change = 0; fill_done = 0;
        sys_valid = 0; psum_in = '0; accum_clr = 0; rd_en = 0; rd_addr = '0;
        model_clear();
        m_base = 0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fifo", fifo_out_ctrl_en, 0);
        chk("rst_memrd", mem_rd_ctrl_en, 0);
        chk("rst_base", accum_wr_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        rstn = 1'b1;
        tick();

        for (int c = 0; c < SC; c++)
            for (int k = 0; k < 4; k++) pat[c][k] = 10 * c + k;
        run_pass(4, 4, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1; rd_addr = k[AW-1:0];
            tick();
            rd_en = 1'b0;
            for (int c = 0; c < SC; c++) chk($sformatf("skew b%0d r%0d", c, k), rd_data[c], 10 * c + k);
        end
        chk("skew_base", accum_wr_addr, 4);

        rand_pat();
        run_pass(252, 1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < SC; c++)
            for (int k = 0; k < 4; k++) pat[c][k] = 1;
        run_pass(4, 4, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            rd_en = 1'b1; rd_addr = k[AW-1:0];
            tick();
            rd_en = 1'b0;
            for (int c = 0; c < SC; c++) chk($sformatf("acc b%0d r%0d", c, k), rd_data[c], 10 * c + k + 1);
        end

        rand_pat();
        run_pass(252, 1, 1'b0, 1'b0, 1'b0);
        clear_pulse();
        for (int c = 0; c < SC; c++)
            for (int k = 0; k < 4; k++) pat[c][k] = 1;
        run_pass(4, 4, 1'b0, 1'b0, 1'b1);
        chk_rows(0, 5);

        rand_pat();
        run_pass(3, 3, 1'b0, 1'b1, 1'b0);
        chk_rows(4, 3);

        en = 1'b1; num_row_in = '0; weight_fill = 1'b1;
        tick();
        en = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_fifo", fifo_out_ctrl_en, 0);
        chk("zero_memrd", mem_rd_ctrl_en, 0);
        tick();
        chk("zero_done_1cyc", done, 0);
        chk("zero_base", accum_wr_addr, 7);

        rand_pat();
        run_pass(247, 2, 1'b1, 1'b1, 1'b0);
        chk("pre_wrap_base", accum_wr_addr, 254);
        rand_pat();
        run_pass(4, 4, 1'b1, 1'b0, 1'b0);
        chk("wrap_base", accum_wr_addr, 2);
        chk_rows(254, 4);

        for (int i = 0; i < 6; i++) begin
            int n;
            n = $urandom_range(1, 8);
            b = m_base;
            rand_pat();
            run_pass(n, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_rows(b, n);
        end

        clear_pulse();
        b = m_base;
        pat[0][0] = 32'h7FFFFFF0; pat[1][0] = 32'h80000010; pat[2][0] = 32'h00000005; pat[3][0] = 32'hFFFFFFFF;
        run_pass(256, 1, 1'b0, 1'b0, 1'b0);
        pat[0][0] = 32'h00000020; pat[1][0] = 32'hFFFFFFE0; pat[2][0] = 32'h00000007; pat[3][0] = 32'h00000002;
        run_pass(256, 1, 1'b0, 1'b0, 1'b0);
        chk("sat_base", accum_wr_addr, b);
        rd_en = 1'b1; rd_addr = b[AW-1:0];
        tick();
        rd_en = 1'b0;
`ifdef ACCUM_SATURATE_EN
        chk("sat_pos", rd_data[0], 32'h7FFFFFFF);
        chk("sat_neg", rd_data[1], 32'h80000000);
`else
        chk("wrap_pos", rd_data[0], 32'h80000010);
        chk("wrap_neg", rd_data[1], 32'h7FFFFFF0);
`endif
        chk("sat_small", rd_data[2], 32'hC);
        chk("sat_mixed", rd_data[3], 32'h1);

        en = 1'b1; num_row_in = 16'd4; weight_fill = 1'b0; weight_change = 1'b0;
        tick();
        en = 1'b0;
        tick();
        sys_valid = 1'b1; psum_in = {$urandom, $urandom, $urandom, $urandom};
        tick(); tick();
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_base", accum_wr_addr, 0);
        chk("abort_done", done, 0);
        sys_valid = 1'b0;
        tick();
        rstn = 1'b1;
        model_clear();
        m_base = 0;
        tick();
        chk_rows(b, 2);
        chk_rows(254, 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
